register_file: RTL and testbench

- General-purpose register file for the KGP miniRISC single-cycle datapath: 32 registers × 32 bits.
- Two combinational read ports feed ALU operands (rs, rt); one synchronous write port is driven by the writeback stage.
- Register 0 is hardwired to zero.

---
 rtl/register_file_if.sv | 24 ++
 rtl/register_file.sv | 37 +++
 tb/tb_register_file.sv | 137 +++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file access bus: two combinational read ports plus one write port.
// The datapath drives indices and write data; the register file returns read data.
interface register_file_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] rs;
   logic [ADDR_WIDTH-1:0] rt;
   logic                  regWrite;
   logic [ADDR_WIDTH-1:0] writeReg;
   logic [DATA_WIDTH-1:0] writeData;
   logic [DATA_WIDTH-1:0] readData1;
   logic [DATA_WIDTH-1:0] readData2;

   modport master (
      output rs, rt, regWrite, writeReg, writeData,
      input  readData1, readData2
   );

   modport slave (
      input  rs, rt, regWrite, writeReg, writeData,
      output readData1, readData2
   );
endinterface

// File: rtl/register_file.sv
// miniRISC general-purpose register file: 32 x 32-bit, two combinational reads,
// one synchronous write, register 0 hardwired to zero, async active-low clear.
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic           clk,
   input  logic           rst,
   register_file_if.slave bus
);

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;

   // Register 0 is never loaded, so it keeps its cleared value forever.
   always_comb begin
      regs_d = regs_q;
      if (bus.regWrite && (bus.writeReg != '0)) begin
         regs_d[bus.writeReg] = bus.writeData;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads come straight from storage: no write-to-read bypass.
   assign bus.readData1 = regs_q[bus.rs];
   assign bus.readData2 = regs_q[bus.rt];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset sweep, writes, gating,
// register 0, no-bypass timing, overwrite and asynchronous mid-operation reset.
module tb_register_file;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;

   logic clk;
   logic rst;
   int   passCount;
   int   totalCount;

   register_file_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) rfBus ();

   register_file #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .NUM_REGS  (NUM_REGS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(rfBus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                input logic [4:0] rsIdx, input logic [4:0] rtIdx);
      rfBus.regWrite  = we;
      rfBus.writeReg  = wr;
      rfBus.writeData = wd;
      rfBus.rs        = rsIdx;
      rfBus.rt        = rtIdx;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
   endtask

   initial begin
      passCount  = 0;
      totalCount = 0;
      rst = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

      // Reset held: sweep every index on both ports
      repeat (2) @(negedge clk);
      for (int i = 0; i < NUM_REGS; i++) begin
         rfBus.rs = 5'(i);
         rfBus.rt = 5'(NUM_REGS - 1 - i);
         #1;
         checkOutput($sformatf("reset_rd1_r%0d", i), rfBus.readData1, 32'd0);
         checkOutput($sformatf("reset_rd2_r%0d", NUM_REGS - 1 - i), rfBus.readData2, 32'd0);
      end

      // Basic writes
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b1, 5'd1, 32'd68, 5'd0, 5'd0);
      @(negedge clk);
      applyStimulus(1'b1, 5'd2, 32'd82, 5'd0, 5'd0);
      @(negedge clk);
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
      #1;
      checkOutput("write_r1", rfBus.readData1, 32'd68);
      checkOutput("write_r2", rfBus.readData2, 32'd82);

      // Write-enable gating
      @(negedge clk);
      applyStimulus(1'b0, 5'd3, 32'hDEADBEEF, 5'd3, 5'd2);
      repeat (3) @(negedge clk);
      checkOutput("gated_r3", rfBus.readData1, 32'd0);
      rfBus.rs = 5'd1;
      #1;
      checkOutput("gated_r1", rfBus.readData1, 32'd68);
      checkOutput("gated_r2", rfBus.readData2, 32'd82);

      // Register 0 ignores writes
      @(negedge clk);
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      @(negedge clk);
      rfBus.regWrite = 1'b0;
      #1;
      checkOutput("zero_rd1", rfBus.readData1, 32'd0);
      checkOutput("zero_rd2", rfBus.readData2, 32'd0);

      // No bypass: old value before the edge, new value after
      @(negedge clk);
      applyStimulus(1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd31);
      #1;
      checkOutput("r31_before_edge", rfBus.readData1, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("r31_after_edge", rfBus.readData1, 32'hFFFFFFFF);
      checkOutput("r31_rs_eq_rt", rfBus.readData2, 32'hFFFFFFFF);

      // Overwrite r1
      @(negedge clk);
      applyStimulus(1'b1, 5'd1, 32'd5, 5'd1, 5'd31);
      @(negedge clk);
      #1;
      checkOutput("overwrite_r1", rfBus.readData1, 32'd5);
      checkOutput("keep_r31", rfBus.readData2, 32'hFFFFFFFF);

      // Async reset between edges with a write pending
      applyStimulus(1'b1, 5'd2, 32'h12345678, 5'd1, 5'd31);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_rst_rd1", rfBus.readData1, 32'd0);
      checkOutput("async_rst_rd2", rfBus.readData2, 32'd0);
      @(posedge clk);
      #1;
      rfBus.rt = 5'd2;
      #1;
      checkOutput("blocked_write_r2", rfBus.readData2, 32'd0);

      // Release and resume normal writes
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b1, 5'd7, 32'hA5A5_0F0F, 5'd7, 5'd1);
      #1;
      checkOutput("post_rst_r1", rfBus.readData2, 32'd0);
      @(negedge clk);
      rfBus.regWrite = 1'b0;
      #1;
      checkOutput("post_rst_write_r7", rfBus.readData1, 32'hA5A5_0F0F);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
